// File: rtl/gpio_in_pkg.sv
// gpio_in_pkg: shared constants for the GPIO input port.
//   - Register offsets seen on the Addr read-select bus.
//   - Default debounce depth.
//   - popcount32: number of set bits in a 32-bit word (transition counting).
package gpio_in_pkg;

    localparam logic [1:0] GPI_LEVEL = 2'd0;
    localparam logic [1:0] GPI_RISE  = 2'd1;
    localparam logic [1:0] GPI_FALL  = 2'd2;
    localparam logic [1:0] GPI_CNT   = 2'd3;

    localparam int GPI_DEBOUNCE_DEFAULT = 4;

    function automatic logic [5:0] popcount32(input logic [31:0] v);
        logic [5:0] n;
        n = '0;
        for (int i = 0; i < 32; i++) n = n + 6'(v[i]);
        return n;
    endfunction

endpackage

// File: rtl/gpio_debounce_bit.sv
// gpio_debounce_bit: one input pin, from raw pad to debounced level.
//   clk, rst : clock and synchronous active-high reset
//   pin      : asynchronous pad input
//   level    : debounced level (registered)
//   rise     : combinational pulse, high on the edge where level goes 0->1
//   fall     : combinational pulse, high on the edge where level goes 1->0
module gpio_debounce_bit
    import gpio_in_pkg::*;
#(
    parameter int DEBOUNCE = GPI_DEBOUNCE_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic pin,
    output logic level,
    output logic rise,
    output logic fall
);

    localparam int            DW    = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
    localparam logic [DW-1:0] DLAST = DW'(DEBOUNCE - 1);

    logic          s1, s2;
    logic [DW-1:0] dcnt;
    logic          accept;

    // s2 has disagreed with level for DEBOUNCE consecutive edges, this one included
    assign accept = (s2 != level) && (dcnt == DLAST);
    assign rise   = accept &  s2;
    assign fall   = accept & ~s2;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            dcnt  <= '0;
            level <= 1'b0;
        end else begin
            s1 <= pin;
            s2 <= s1;
            if (s2 == level) begin
                dcnt <= '0;
            end else if (accept) begin
                level <= s2;
                dcnt  <= '0;
            end else begin
                dcnt <= dcnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/gpio_input_port.sv
// gpio_input_port: WIDTH debounced input pins with sticky edge flags,
// transition counter and maskable interrupt, read by the core through a
// combinational port.
//   CLK, RST : clock, synchronous active-high reset
//   PinsIn   : asynchronous pads
//   Addr     : read select (level / rise flags / fall flags / {mask,count})
//   RD       : combinational read data, zero-extended
//   WD       : write data for the control strobes below
//   ClrRise  : rise flags &= ~WD
//   ClrFall  : fall flags &= ~WD
//   MaskWE   : interrupt mask <= WD
//   CntClr   : restart the transition counter
//   IRQ      : registered OR of masked flags
module gpio_input_port
    import gpio_in_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int DEBOUNCE = GPI_DEBOUNCE_DEFAULT,
    parameter int CNT_W    = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] PinsIn,
    input  logic [1:0]       Addr,
    output logic [31:0]      RD,
    input  logic [31:0]      WD,
    input  logic             ClrRise,
    input  logic             ClrFall,
    input  logic             MaskWE,
    input  logic             CntClr,
    output logic             IRQ
);

    logic [WIDTH-1:0] level, rise, fall;
    logic [WIDTH-1:0] rise_flags, fall_flags, int_mask;
    logic [WIDTH-1:0] clr_rise, clr_fall;
    logic [CNT_W-1:0] count;
    logic [5:0]       n_edges;
    logic             unused_wd;

    for (genvar i = 0; i < WIDTH; i++) begin : g_pin
        gpio_debounce_bit #(.DEBOUNCE(DEBOUNCE)) u_bit (
            .clk  (CLK),
            .rst  (RST),
            .pin  (PinsIn[i]),
            .level(level[i]),
            .rise (rise[i]),
            .fall (fall[i])
        );
    end

    assign clr_rise  = ClrRise ? WD[WIDTH-1:0] : '0;
    assign clr_fall  = ClrFall ? WD[WIDTH-1:0] : '0;
    assign n_edges   = popcount32(32'(rise | fall));
    assign unused_wd = ^WD;

    always_ff @(posedge CLK) begin
        if (RST) begin
            rise_flags <= '0;
            fall_flags <= '0;
            int_mask   <= '0;
            count      <= '0;
            IRQ        <= 1'b0;
        end else begin
            // OR the new edge in after the clear so a colliding event survives
            rise_flags <= (rise_flags & ~clr_rise) | rise;
            fall_flags <= (fall_flags & ~clr_fall) | fall;
            if (MaskWE) int_mask <= WD[WIDTH-1:0];
            // a clear only discards the old value; this cycle's edges still count
            count <= (CntClr ? '0 : count) + CNT_W'(n_edges);
            IRQ   <= |((rise_flags | fall_flags) & int_mask);
        end
    end

    always_comb begin
        RD = '0;
        unique case (Addr)
            GPI_LEVEL: RD = 32'(level);
            GPI_RISE:  RD = 32'(rise_flags);
            GPI_FALL:  RD = 32'(fall_flags);
            GPI_CNT:   RD = {16'(int_mask), 16'(count)};
            default:   RD = '0;
        endcase
    end

endmodule

// File: tb/tb_gpio_input_port.sv
// Scoreboard bench for gpio_input_port. The reference model keeps a window of
// raw pin samples and accepts a new level when every sample in the window
// disagrees with the current level; flags, mask, counter and IRQ follow the
// register rules directly.
module tb_gpio_input_port;

    localparam int DEB = 4;

    logic        CLK = 1'b0;
    logic        RST;
    logic [7:0]  PinsIn;
    logic [1:0]  Addr;
    logic [31:0] RD, WD;
    logic        ClrRise, ClrFall, MaskWE, CntClr, IRQ;

    always #5 CLK = ~CLK;

    gpio_input_port #(.WIDTH(8), .DEBOUNCE(DEB), .CNT_W(16)) dut (
        .CLK(CLK), .RST(RST), .PinsIn(PinsIn), .Addr(Addr), .RD(RD), .WD(WD),
        .ClrRise(ClrRise), .ClrFall(ClrFall), .MaskWE(MaskWE), .CntClr(CntClr),
        .IRQ(IRQ)
    );

    typedef struct {
        logic [31:0] rd;
        logic        irq;
        int          cyc;
        logic [1:0]  addr;
    } exp_t;

    exp_t sb[$];
    int   compared   = 0;
    int   mismatched = 0;
    int   cyc        = 0;

    // reference state; hist[0] is the newest pin sample taken at an edge
    logic [7:0]  hist [0:DEB];
    logic [7:0]  m_lvl, m_rf, m_ff, m_mask;
    logic [15:0] m_cnt;
    logic        m_irq;
    logic [7:0]  cur_pins;

    function automatic logic [31:0] model_rd(input logic [1:0] a);
        case (a)
            2'd0:    return {24'd0, m_lvl};
            2'd1:    return {24'd0, m_rf};
            2'd2:    return {24'd0, m_ff};
            default: return {8'd0, m_mask, m_cnt};
        endcase
    endfunction

    task automatic model_edge(input logic [7:0] pins, input logic [31:0] wd,
                              input logic cr, cf, mwe, cc, rst);
        logic [7:0] acc, r, f;
        logic       irq_n;
        if (rst) begin
            for (int j = 0; j <= DEB; j++) hist[j] = 8'h00;
            m_lvl = 0; m_rf = 0; m_ff = 0; m_mask = 0; m_cnt = 0; m_irq = 0;
        end else begin
            // samples taken 2..DEB+1 edges ago are what the debouncer has seen
            for (int i = 0; i < 8; i++) begin
                acc[i] = 1'b1;
                for (int j = 1; j <= DEB; j++)
                    if (hist[j][i] == m_lvl[i]) acc[i] = 1'b0;
            end
            r     = acc & ~m_lvl;
            f     = acc & m_lvl;
            irq_n = |((m_rf | m_ff) & m_mask);
            m_rf  = (m_rf & ~(cr ? wd[7:0] : 8'h00)) | r;
            m_ff  = (m_ff & ~(cf ? wd[7:0] : 8'h00)) | f;
            if (mwe) m_mask = wd[7:0];
            m_cnt = (cc ? 16'd0 : m_cnt) + 16'($countones(r | f));
            m_lvl = m_lvl ^ acc;
            m_irq = irq_n;
            for (int j = DEB; j >= 1; j--) hist[j] = hist[j-1];
            hist[0] = pins;
        end
    endtask

    task automatic step(input logic [7:0] pins, input logic [1:0] a,
                        input logic [31:0] wd, input logic cr, cf, mwe, cc, rst);
        exp_t e;
        PinsIn = pins; Addr = a; WD = wd;
        ClrRise = cr; ClrFall = cf; MaskWE = mwe; CntClr = cc; RST = rst;
        cur_pins = pins;
        e.rd = model_rd(a); e.irq = m_irq; e.cyc = cyc; e.addr = a;
        sb.push_back(e);
        @(posedge CLK);
        model_edge(pins, wd, cr, cf, mwe, cc, rst);
        cyc++;
        #1;
    endtask

    task automatic hold(input logic [7:0] pins, input int n);
        for (int k = 0; k < n; k++) step(pins, 2'(k), 32'd0, 0, 0, 0, 0, 0);
    endtask

    // monitor: one expectation per cycle, checked mid-cycle
    initial begin
        exp_t e;
        forever begin
            @(negedge CLK);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                compared++;
                if (RD !== e.rd || IRQ !== e.irq) begin
                    mismatched++;
                    $display("FAIL rd_irq cyc=%0d addr=%0d rd=%h want=%h irq=%b want=%b",
                             e.cyc, e.addr, RD, e.rd, IRQ, e.irq);
                end
            end
        end
    end

    initial begin
        logic [7:0] p;
        PinsIn = 0; Addr = 0; WD = 0; ClrRise = 0; ClrFall = 0;
        MaskWE = 0; CntClr = 0; RST = 1; cur_pins = 0;
        repeat (2) begin
            @(posedge CLK);
            model_edge(8'h00, 32'd0, 0, 0, 0, 0, 1);
        end
        #1;
        // reset state at every address
        for (int a = 0; a < 4; a++) step(8'h00, 2'(a), 32'd0, 0, 0, 0, 0, 1);
        hold(8'h00, 4);

        // pin0 rise: watch the level register for exact latency
        for (int k = 0; k < 8; k++) step(8'h01, 2'd0, 32'd0, 0, 0, 0, 0, 0);
        hold(8'h01, 4);

        // pin3 three-cycle glitch never reaches the level
        hold(8'h09, 3);
        hold(8'h01, 10);

        // interrupt: clear flags, mask pin0, then a fresh pin0 rise
        hold(8'h00, 8);
        step(8'h00, 2'd1, 32'hFF, 1, 1, 0, 0, 0);
        step(8'h00, 2'd3, 32'h01, 0, 0, 1, 0, 0);
        hold(8'h00, 3);
        hold(8'h01, 9);
        step(8'h01, 2'd1, 32'h01, 1, 0, 0, 0, 0);   // clear pin0 rise
        hold(8'h01, 3);
        hold(8'h00, 8);
        step(8'h00, 2'd2, 32'h01, 0, 1, 0, 0, 0);   // clear pin0 fall
        hold(8'h00, 3);
        // clear lands on the same edge a new pin0 rise is accepted
        step(8'h01, 2'd1, 32'd0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 4; k++) step(8'h01, 2'd1, 32'd0, 0, 0, 0, 0, 0);
        step(8'h01, 2'd1, 32'h01, 1, 0, 0, 0, 0);
        hold(8'h01, 4);

        // counter wrap: 8191 toggles of all 8 pins, then 7 falls -> 0xFFFF
        hold(8'h00, 8);
        step(8'h00, 2'd3, 32'd0, 0, 0, 0, 1, 0);
        for (int t = 0; t < 8191; t++) begin
            p = (t % 2 == 0) ? 8'hFF : 8'h00;
            for (int k = 0; k < 4; k++) step(p, 2'd3, 32'd0, 0, 0, 0, 0, 0);
        end
        hold(8'hFF, 8);
        for (int k = 0; k < 8; k++) step(8'h01, 2'd3, 32'd0, 0, 0, 0, 0, 0);
        // pin0 fall + pin1 rise on one edge wraps the counter to 1
        for (int k = 0; k < 8; k++) step(8'h02, 2'd3, 32'd0, 0, 0, 0, 0, 0);
        // counter clear on an edge that accepts one transition
        step(8'h03, 2'd3, 32'd0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 4; k++) step(8'h03, 2'd3, 32'd0, 0, 0, 0, 0, 0);
        step(8'h03, 2'd3, 32'd0, 0, 0, 0, 1, 0);
        hold(8'h03, 4);

        // reset while pin5 rise is two counts into debounce
        step(8'h23, 2'd0, 32'd0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 3; k++) step(8'h23, 2'd0, 32'd0, 0, 0, 0, 0, 0);
        step(8'h03, 2'd0, 32'd0, 0, 0, 0, 0, 1);
        for (int k = 0; k < 12; k++) step(8'h03, 2'(k), 32'd0, 0, 0, 0, 0, 0);

        // random traffic
        for (int k = 0; k < 3000; k++) begin
            p = cur_pins;
            for (int i = 0; i < 8; i++)
                if ($urandom_range(0, 7) == 0) p[i] = ~p[i];
            step(p, 2'($urandom_range(0, 3)), $urandom,
                 $urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0,
                 $urandom_range(0, 15) == 0, $urandom_range(0, 31) == 0,
                 $urandom_range(0, 499) == 0);
        end

        repeat (2) @(negedge CLK);
        #1;
        if (sb.size() != 0) begin
            compared++;
            mismatched++;
            $display("FAIL scoreboard_drain left=%0d want=0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
